// File: rtl/playback_sequencer.sv
// ---------------------------------------------------------------------------
// playback_sequencer
//
// Record/playback controller. Each save pulse writes one entry into an
// external dual-port RAM at the next free slot (up to DEPTH entries). An
// execute pulse, or filling the last slot, replays the stored entries. Each
// entry gets one READ cycle followed by max(step_ticks,1) SHOW cycles. The
// block owns its entry count, read pointer and interval timer. The write
// pointer is simply the low bits of the entry count.
//
// Ports:
//   clk, reset_n   system clock, asynchronous active-low reset
//   save           one-cycle pulse, records one entry
//   execute        one-cycle pulse, starts playback
//   clear          synchronous abort back to IDLE, entries discarded
//   step_ticks     SHOW duration in clock cycles (0 behaves as 1)
//   wr_en/wr_addr  RAM write strobe and address
//   rd_en/rd_addr  RAM read strobe and address
//   count          number of stored entries (0..DEPTH)
//   busy           high while in READ or SHOW
//   done           one-cycle pulse when playback of the last entry ends
//   lights         status LEDs: IDLE 001, WAIT 010, SHOW 100, SAVE/READ 111
//
// Build option:
//   PLAYBACK_LOOP_EN  When defined, playback loops forever. After the last
//                     entry the read pointer wraps to 0, and done pulses
//                     together with that READ. Only clear or reset_n stops it.
// ---------------------------------------------------------------------------
module playback_sequencer #(
    parameter  int DEPTH  = 16,
    parameter  int TICK_W = 24,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              save,
    input  logic              execute,
    input  logic              clear,
    input  logic [TICK_W-1:0] step_ticks,
    output logic              wr_en,
    output logic [AW-1:0]     wr_addr,
    output logic              rd_en,
    output logic [AW-1:0]     rd_addr,
    output logic [AW:0]       count,
    output logic              busy,
    output logic              done,
    output logic [2:0]        lights
);

    typedef enum logic [2:0] {
        IDLE,
        SAVE,
        WAIT,
        READ,
        SHOW
    } state_t;

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    state_t            state_q;
    state_t            state_d;
    logic [AW:0]       count_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [TICK_W-1:0] timer_q;
    logic              done_q;

    logic              full;
    logic              last_entry;
    logic              show_expired;
    logic [TICK_W-1:0] load_value;

    // Status terms shared by the next-state logic and the datapath.
    // A zero interval is loaded as 0, so SHOW still lasts one cycle.
    always_comb begin
        full         = (count_q == FULL_COUNT);
        last_entry   = (({1'b0, rd_ptr_q} + (AW+1)'(1)) == count_q);
        show_expired = (state_q == SHOW) && !clear && (timer_q == '0);
        load_value   = (step_ticks == '0) ? '0 : (step_ticks - TICK_W'(1));
    end

    // Next-state decode. clear beats save, and save beats execute or full.
    // A save while full is dropped because full sends WAIT straight to READ.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!clear && save) begin
                    state_d = SAVE;
                end
            end
            SAVE: begin
                state_d = clear ? IDLE : WAIT;
            end
            WAIT: begin
                if (clear) begin
                    state_d = IDLE;
                end else if (save && !full) begin
                    state_d = SAVE;
                end else if (execute || full) begin
                    state_d = READ;
                end
            end
            READ: begin
                state_d = clear ? IDLE : SHOW;
            end
            SHOW: begin
                if (clear) begin
                    state_d = IDLE;
                end else if (timer_q == '0) begin
`ifdef PLAYBACK_LOOP_EN
                    state_d = READ;
`else
                    state_d = last_entry ? IDLE : READ;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register and datapath. Entering or staying in IDLE wipes count,
    // read pointer and timer. done is registered from the final SHOW expiry.
    // Without looping it therefore shows in the first IDLE cycle. With
    // looping it shows alongside the wrap-around READ.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            rd_ptr_q <= '0;
            timer_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= show_expired && last_entry;
            if (state_d == IDLE) begin
                count_q  <= '0;
                rd_ptr_q <= '0;
                timer_q  <= '0;
            end else begin
                case (state_q)
                    SAVE: begin
                        count_q <= count_q + (AW+1)'(1);
                    end
                    WAIT: begin
                        if (state_d == READ) begin
                            rd_ptr_q <= '0;
                        end
                    end
                    READ: begin
                        timer_q <= load_value;
                    end
                    SHOW: begin
                        if (!show_expired) begin
                            timer_q <= timer_q - TICK_W'(1);
                        end else begin
                            rd_ptr_q <= last_entry ? '0 : (rd_ptr_q + AW'(1));
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Output decode from registered state. The only input-to-output path
    // is clear gating wr_en, so an aborted SAVE never writes the RAM.
    always_comb begin
        wr_en   = (state_q == SAVE) && !clear;
        wr_addr = count_q[AW-1:0];
        rd_en   = (state_q == READ);
        rd_addr = rd_ptr_q;
        count   = count_q;
        busy    = (state_q == READ) || (state_q == SHOW);
        done    = done_q;
    end

    // Status LEDs.
    always_comb begin
        lights = 3'b001;
        case (state_q)
            IDLE:    lights = 3'b001;
            WAIT:    lights = 3'b010;
            SHOW:    lights = 3'b100;
            SAVE:    lights = 3'b111;
            READ:    lights = 3'b111;
            default: lights = 3'b001;
        endcase
    end

endmodule

// File: doc/playback_sequencer.md
Name: playback_sequencer

Overview:
- Parametrised record/playback controller: captures up to DEPTH entries into an external dual-port RAM, then replays them one entry per programmable interval.
- Successor to the fixed-function save/execute controller. Owns its own write/read pointers, entry count and interval timer, so no external FIFO or timer is needed.
- Sits between the debounced user inputs and the storage RAM / display path.

Parameters:
- DEPTH, 16: maximum stored entries. Must be a power of two, ≥2. AW = $clog2(DEPTH) is derived internally.
- TICK_W, 24: width of the step_ticks interval input.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- save  in  1  single-cycle pulse, already synchronised: record one entry
- execute  in  1  single-cycle pulse: start playback
- clear  in  1  synchronous soft abort: return to IDLE, discard entries
- step_ticks  in  TICK_W  SHOW duration in clk cycles; 0 is treated as 1
- wr_en  out  1  RAM write strobe
- wr_addr  out  AW  RAM write address
- rd_en  out  1  RAM read strobe
- rd_addr  out  AW  RAM read address
- count  out  AW+1  number of stored entries
- busy  out  1  high in READ and SHOW
- done  out  1  one-cycle pulse when playback of the last entry ends
- lights  out  3  status LEDs

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = IDLE; count, write pointer, read pointer and timer = 0.
  - wr_en = rd_en = busy = done = 0; wr_addr = rd_addr = 0; lights = 3'b001.
- All outputs are decoded from registered state/counters only. No input-to-output combinational path, except wr_en (see SAVE).
- Priority in every state: clear > save > execute/full.
- States and transitions:
  - IDLE: count held at 0. save → SAVE. Otherwise stay.
  - SAVE (1 cycle):
    - wr_en = !clear; wr_addr = count.
    - If no clear: count += 1 at cycle end, → WAIT.
    - clear → IDLE, no write.
  - WAIT:
    - clear → IDLE.
    - save with count < DEPTH → SAVE.
    - execute, or count == DEPTH → READ with read pointer = 0.
    - Simultaneous save+execute with count < DEPTH → SAVE.
    - save while full is ignored; the full condition wins.
  - READ (1 cycle):
    - rd_en = 1; rd_addr = read pointer.
    - Timer loaded with max(step_ticks,1) − 1, sampled this cycle.
    - → SHOW; clear → IDLE.
  - SHOW: timer decrements each cycle. At timer == 0:
    - If read pointer + 1 == count: → IDLE, done = 1 in the first IDLE cycle.
    - Else: read pointer += 1, → READ.
    - clear → IDLE at any cycle, no done.
- Timing:
  - save sampled in cycle n → wr_en high in cycle n+1 at the old count.
  - Entry period = max(step_ticks,1) + 1 cycles (1 READ + T SHOW).
  - step_ticks changes take effect at the next READ.
- Entry to IDLE from any state clears count, both pointers and timer.
- count never exceeds DEPTH. Pointers are AW bits and never wrap during recording.
- lights: IDLE 001, WAIT 010, SHOW 100, SAVE/READ 111.
- Reset asserted mid-operation aborts immediately; the RAM contents are don't-care afterwards.

Optional Feature:
- Macro: PLAYBACK_LOOP_EN.
- Defined:
  - At the end of the last entry's SHOW, read pointer wraps to 0 and → READ.
  - done pulses for 1 cycle at each wrap, concurrent with that READ.
  - Playback exits only via clear or reset_n.
- Undefined: playback ends in IDLE as specified above.

Test Plan:
1. Reset: reset_n low during SHOW with rd_addr = 2 → same-edge-independent clear of all outputs to reset values, lights = 001; after release, state stays IDLE.
2. Record/play: 3 save pulses, then execute, step_ticks = 4 → wr_addr 0,1,2 with count = 3; rd_en pulses at addr 0,1,2 spaced 5 cycles; done pulse one cycle after the last SHOW; count = 0, lights = 001.
3. Full: DEPTH = 4, 4 saves, no execute → READ entered the cycle after the 4th WAIT; a 5th save in that WAIT produces no wr_en.
4. Clear: clear in the 2nd SHOW cycle → IDLE next cycle, no further rd_en, done = 0, count = 0; clear coincident with SAVE → wr_en = 0.
5. Zero interval: step_ticks = 0 with 2 entries → rd_en pulses 2 cycles apart; save+execute together in WAIT → SAVE taken.
6. PLAYBACK_LOOP_EN: 2 entries, step_ticks = 1 → rd_addr sequence 0,1,0,1… with done at each wrap; clear stops playback.
